ram_sync_clr: RTL and testbench
===============================

// Module: ram_sync_clr
// PURPOSE
//   Parametrised synchronous single-port data RAM for the CPU datapath; successor to the
//   asynchronous 4-bit x 4096 data memory. Same addressing ({oprnd, program_byte}) and
//   chips/enableRW control. Adds registered reads with a valid strobe, split data in/out,
//   and a hardware clear engine that zero-fills the array after reset or on request.
// PARAMETERS
//   DATA_W     4   data word width in bits
//   ADDR_HI_W  4   width of oprnd (upper address field)
//   ADDR_LO_W  8   width of program_byte (lower address field)
//   DEPTH      derived = 2**(ADDR_HI_W+ADDR_LO_W) words (local, not overridable)
// PORTS
//   clock         in   1          rising-edge clock
//   reset         in   1          asynchronous, active-low reset
//   chips         in   1          chip select; access occurs only when 1
//   enableRW      in   1          1 = write, 0 = read (qualified by chips)
//   oprnd         in   ADDR_HI_W  address upper field
//   program_byte  in   ADDR_LO_W  address lower field
//   data_in       in   DATA_W     write data
//   clear_req     in   1          1-cycle pulse: start zero-fill of whole array
//   data_out      out  DATA_W     registered read data
//   data_valid    out  1          1-cycle pulse: data_out updated this cycle
//   busy          out  1          1 while clear engine owns the array
// BEHAVIOUR
//   Address: addr = {oprnd, program_byte}, ADDR_HI_W+ADDR_LO_W bits, no translation.
//   Reset (reset=0, async): state=CLEAR, clr_addr=0, data_out=0, data_valid=0, busy=1.
//     Array contents are not reset directly; the CLEAR sweep zeroes them after release.
//   FSM states: CLEAR, IDLE.
//     CLEAR: each clock writes 0 to mem[clr_addr], clr_addr++. On the edge where
//       clr_addr == DEPTH-1 is written -> IDLE. Sweep takes exactly DEPTH cycles.
//       busy=1 throughout; busy drops to 0 on the first IDLE cycle.
//     IDLE: busy=0. clear_req=1 sampled -> CLEAR with clr_addr=0 (no access serviced
//       that cycle, even if chips=1). Otherwise service access below.
//   Write (IDLE, chips=1, enableRW=1): mem[addr] <= data_in at the rising edge.
//     data_out and data_valid unchanged/0.
//   Read (IDLE, chips=1, enableRW=0): data_out <= mem[addr] at the edge; data_valid=1
//     for the following cycle only. Latency 1 cycle. Back-to-back reads give one valid
//     per cycle.
//   Read of an address written in an earlier cycle returns the new data (write-first
//     across cycles; no same-cycle read+write possible on one port).
//   chips=0: no access; data_valid=0; data_out holds last read value.
//   Accesses while busy=1 are dropped silently: no write, data_valid stays 0.
//   clear_req while already in CLEAR: ignored (sweep continues, not restarted).
//   Reset asserted mid-sweep or mid-read: immediate return to reset values; sweep
//     restarts from address 0 after release.
//   clr_addr is ADDR_HI_W+ADDR_LO_W bits; terminal compare on DEPTH-1, no wrap used.
//   No tri-state on any port; data_out is always driven.
// TESTING
//   1. Reset release, defaults: busy=1 for exactly 4096 cycles, then 0; data_out=0,
//      data_valid=0 throughout; read of addr 0xFFF afterwards returns 0x0.
//   2. Write 0xA to {oprnd=3, program_byte=0x5C}; read same address next cycle ->
//      data_valid=1 one cycle later with data_out=0xA; next idle cycle data_valid=0.
//   3. Back-to-back reads of 0x000..0x003 pre-written 1,2,3,4 -> data_out 1,2,3,4 on
//      4 consecutive cycles, data_valid high for all 4.
//   4. Write 0x7 to 0x123, pulse clear_req, attempt write 0x5 to 0x124 while busy ->
//      after sweep, reads of 0x123 and 0x124 both return 0x0; no data_valid during busy.
//   5. Assert reset at sweep cycle 2000 for 3 cycles -> outputs at reset values at once;
//      busy then stays 1 for a full 4096 cycles after release.
//   6. DATA_W=8, ADDR_HI_W=2, ADDR_LO_W=4 build: sweep = 64 cycles; write 0xC3 to
//      addr 0x2F, read back 0xC3.

Source files
------------

// File: rtl/ram_sync_clr.sv
// Synchronous single-port data RAM, address {oprnd, program_byte}, with a registered read,
// a one-cycle valid strobe and a zero-fill engine that owns the array after reset or on request.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | writing 0 to mem[clr_addr] each cycle, busy=1, accesses dropped
// ST_IDLE  | servicing chips/enableRW accesses, busy=0
module ram_sync_clr #(
  parameter int DATA_W    = 4,
  parameter int ADDR_HI_W = 4,
  parameter int ADDR_LO_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 chips,
  input  logic                 enableRW,
  input  logic [ADDR_HI_W-1:0] oprnd,
  input  logic [ADDR_LO_W-1:0] program_byte,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 clear_req,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid,
  output logic                 busy
);

  localparam int AW    = ADDR_HI_W + ADDR_LO_W;
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]        state;
  logic [AW-1:0]     clr_addr;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              clearing;
  logic              access_ok;
  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [DATA_W-1:0] mem_wd;

  assign addr      = {oprnd, program_byte};
  assign clearing  = (state == ST_CLEAR);
  assign busy      = clearing;
  // A clear request takes priority over any access presented in the same cycle.
  assign access_ok = (state == ST_IDLE) && !clear_req && chips;

  assign mem_we = clearing || (access_ok && enableRW);
  assign mem_wa = clearing ? clr_addr : addr;
  assign mem_wd = clearing ? '0 : data_in;

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_CLEAR;
      clr_addr   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST_ADDR) state <= ST_IDLE;
        end
        default: begin
          if (clear_req) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
          end else if (chips && !enableRW) begin
            data_out   <= mem[addr];
            data_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sync_clr.sv
// Bench for ram_sync_clr: directed scenarios plus random traffic against an array-based model,
// and a second small-geometry instance.
module tb_ram_sync_clr;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       chips = 1'b0, enableRW = 1'b0, clear_req = 1'b0;
  logic [3:0] oprnd = '0;
  logic [7:0] program_byte = '0;
  logic [3:0] data_in = '0;
  logic [3:0] data_out;
  logic       data_valid, busy;

  logic       s_reset = 1'b0;
  logic       s_chips = 1'b0, s_we = 1'b0, s_clr = 1'b0;
  logic [1:0] s_oprnd = '0;
  logic [3:0] s_pb = '0;
  logic [7:0] s_din = '0;
  logic [7:0] s_dout;
  logic       s_valid, s_busy;

  int n_total = 0;
  int n_bad   = 0;

  int   ref_mem [4096];
  int   busy_left = 0;
  int   exp_dout  = 0;
  bit   exp_valid = 1'b0;

  always #5 clock = ~clock;

  ram_sync_clr dut (
    .clock(clock), .reset(reset), .chips(chips), .enableRW(enableRW),
    .oprnd(oprnd), .program_byte(program_byte), .data_in(data_in),
    .clear_req(clear_req), .data_out(data_out), .data_valid(data_valid), .busy(busy)
  );

  ram_sync_clr #(.DATA_W(8), .ADDR_HI_W(2), .ADDR_LO_W(4)) dut_s (
    .clock(clock), .reset(s_reset), .chips(s_chips), .enableRW(s_we),
    .oprnd(s_oprnd), .program_byte(s_pb), .data_in(s_din),
    .clear_req(s_clr), .data_out(s_dout), .data_valid(s_valid), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".busy"},  32'(busy), 32'(busy_left > 0));
    chk({tag, ".valid"}, 32'(data_valid), 32'(exp_valid));
    chk({tag, ".dout"},  32'(data_out), 32'(exp_dout));
  endtask

  // Model: a clear makes the array all-zero and blocks every access for 4096 edges.
  task automatic model_edge(input bit cs, input bit we, input int a, input int d, input bit clr);
    if (busy_left > 0) begin
      busy_left--;
      exp_valid = 1'b0;
    end else if (clr) begin
      busy_left = 4096;
      exp_valid = 1'b0;
      foreach (ref_mem[i]) ref_mem[i] = 0;
    end else if (cs && we) begin
      ref_mem[a] = d % 16;
      exp_valid  = 1'b0;
    end else if (cs) begin
      exp_dout  = ref_mem[a];
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic step(input string tag, input bit cs, input bit we, input int a, input int d,
                      input bit clr);
    logic [11:0] a12;
    a12 = a[11:0];
    chips = cs; enableRW = we; oprnd = a12[11:8]; program_byte = a12[7:0];
    data_in = d[3:0]; clear_req = clr;
    @(posedge clock);
    model_edge(cs, we, a, d, clr);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b0;
    busy_left = 4096; exp_dout = 0; exp_valid = 1'b0;
    foreach (ref_mem[i]) ref_mem[i] = 0;
    #1;
    check_outputs("reset_now");
    repeat (hold) begin
      @(posedge clock); #1;
      check_outputs("reset_hold");
    end
    reset = 1'b1;
  endtask

  initial begin
    int a, d;
    foreach (ref_mem[i]) ref_mem[i] = 0;
    @(posedge clock); #1;

    // 1: power-up sweep, then read of the top address
    do_reset(3);
    repeat (4096) step("sweep0", 1'b0, 1'b0, 0, 0, 1'b0);
    step("rd_fff", 1'b1, 1'b0, 12'hFFF, 0, 1'b0);

    // 2: write then read back, strobe lasts one cycle
    step("wr_35c", 1'b1, 1'b1, 12'h35C, 4'hA, 1'b0);
    step("rd_35c", 1'b1, 1'b0, 12'h35C, 0, 1'b0);
    step("idle_35c", 1'b0, 1'b0, 0, 0, 1'b0);

    // 3: back-to-back reads
    for (int i = 0; i < 4; i++) step("wr_seq", 1'b1, 1'b1, i, i + 1, 1'b0);
    for (int i = 0; i < 4; i++) step("rd_seq", 1'b1, 1'b0, i, 0, 1'b0);
    step("idle_seq", 1'b0, 1'b0, 0, 0, 1'b0);

    // 4: clear drops writes presented while busy, repeated clear_req ignored
    step("wr_123", 1'b1, 1'b1, 12'h123, 7, 1'b0);
    step("clr_req", 1'b1, 1'b1, 12'h200, 9, 1'b1);
    step("wr_busy", 1'b1, 1'b1, 12'h124, 5, 1'b0);
    for (int i = 0; i < 4094; i++)
      step("sweep4", 1'b1, i[0], 12'h124, 5, (i == 1000));
    step("rd_123", 1'b1, 1'b0, 12'h123, 0, 1'b0);
    step("rd_124", 1'b1, 1'b0, 12'h124, 0, 1'b0);
    step("rd_200", 1'b1, 1'b0, 12'h200, 0, 1'b0);

    // 5: reset mid-sweep restarts a full sweep
    step("clr_req5", 1'b0, 1'b0, 0, 0, 1'b1);
    repeat (1999) step("sweep5", 1'b0, 1'b0, 0, 0, 1'b0);
    do_reset(3);
    repeat (4096) step("sweep5b", 1'(($urandom) & 1), 1'(($urandom) & 1),
                       $urandom_range(0, 4095), $urandom_range(0, 15), 1'b0);

    // random traffic over a small address pool, occasional clear
    for (int i = 0; i < 2500; i++) begin
      a = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) a += 12'hFF0;
      d = $urandom_range(0, 15);
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, d,
           ($urandom_range(0, 1499) == 0));
    end

    // 6: small geometry instance, 64-cycle sweep
    s_reset = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(posedge clock); #1;
      chk("s_busy", 32'(s_busy), 32'(i < 64));
      chk("s_valid_sweep", 32'(s_valid), 32'(0));
    end
    s_chips = 1'b1; s_we = 1'b1; s_oprnd = 2'd2; s_pb = 4'hF; s_din = 8'hC3;
    @(posedge clock); #1;
    chk("s_valid_wr", 32'(s_valid), 32'(0));
    s_we = 1'b0;
    @(posedge clock); #1;
    chk("s_valid_rd", 32'(s_valid), 32'(1));
    chk("s_dout_rd", 32'(s_dout), 32'h0C3);
    s_chips = 1'b0;
    @(posedge clock); #1;
    chk("s_valid_idle", 32'(s_valid), 32'(0));
    chk("s_dout_hold", 32'(s_dout), 32'h0C3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
